sr_to_jk: RTL and testbench
===========================

Name: sr_to_jk

Overview:
- Single-bit JK flip-flop built around an internal SR flip-flop core, using the classic SR-to-JK conversion (feedback of Q into the S/R gating).
- Provides true and complementary outputs.
- Used as a teaching/reference storage element and as a building block for counters and toggle logic.
- Purely synchronous: one clock domain, no asynchronous paths.

Parameters:
- None. The block is fixed at one bit of state.

Ports:
- clk    input   1  clock; all state changes on rising edge.
- rst    input   1  synchronous, active-high reset; sampled on rising clk.
- q_     output  1  flip-flop state Q.
- q_bar  output  1  complement of Q; always equals ~q_.
- JK     input   2  control pair: JK[1] = J, JK[0] = K.
- Positional instantiation order is fixed as (q_, q_bar, clk, rst, JK). Existing instantiations connect by position.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Both are already decided.
- All updates happen on the rising edge of clk only. Inputs are don't-care between edges.
- Reset: if rst = 1 at a rising edge, then q_ <= 0 and q_bar = 1. Reset has priority over J/K.
- Power-on/initial state: the state register initialises to 0 (q_ = 0, q_bar = 1), so outputs are defined before the first sampled reset.
- Next-state at a rising edge with rst = 0 is selected by decoding JK directly. It does not depend on the present Q being known, so X-propagation is avoided:
  - JK = 00: hold; Q unchanged.
  - JK = 10: set; Q = 1.
  - JK = 01: reset; Q = 0.
  - JK = 11: toggle; Q = ~Q, once per rising edge for as long as JK = 11 is held.
- SR conversion (internal, for structural implementations): S = J & ~Q, R = K & Q.
  - The SR core must never receive S = R = 1. The conversion guarantees this.
  - If the SR core is used, its next-state function is Q+ = S | (~R & Q). Set/reset/hold cases must still resolve without relying on a known Q. Guard with an explicit decode if needed.
- q_bar is combinationally derived as ~q_. It is never an independent register, so the two outputs cannot disagree.
- Latency: exactly one clock. A change on JK is reflected on q_ after the next rising edge.
- Reset mid-toggle: rst = 1 forces Q = 0 at that edge regardless of JK. Normal decoding resumes at the first edge with rst = 0.
- No combinational path from JK or rst to the outputs.

Decomposition:
- Shared package: a localparam/enum for the JK command encodings (HOLD = 2'b00, RST = 2'b01, SET = 2'b10, TOG = 2'b11) and the reset value of Q (1'b0).
- One natural sub-module: sr_ff.
  - Clocked SR flip-flop with synchronous active-high reset.
  - Outputs q and q_n; S = R = 1 is an illegal input.
  - sr_to_jk instantiates it and contains only the S/R gating logic.
- Optional assertions in sr_to_jk:
  - q_bar == ~q_ at all times.
  - S & R never both 1 into sr_ff.

Test Plan:
- Reset: rst = 1, JK = 00 across a rising edge -> q_ = 0, q_bar = 1. Then rst = 0, JK = 00 for 2 edges -> q_ stays 0.
- Set then hold: JK = 10 for 2 edges -> q_ = 1 after the first edge. Then JK = 00 -> q_ remains 1 and q_bar = 0.
- Reset command: from q_ = 1, apply JK = 01 -> q_ = 0 after one edge. Hold it for 2 edges -> stays 0.
- Toggle: from q_ = 0, apply JK = 11 for 4 edges -> q_ sequence 1, 0, 1, 0. q_bar is the exact complement at every edge.
- Sequence check (50 ns clock period, changes every 100 ns): JK = 10, 01, 11, 00, 10 -> q_ = 1, 0, toggling each edge, held at last value, 1.
- Reset priority: with JK = 11 toggling, assert rst = 1 for one edge -> q_ = 0. Then deassert -> toggling resumes from 0 (first edge gives 1).

Source files
------------

// File: rtl/sr_to_jk_pkg.sv
// Shared definitions for the JK flip-flop built on an SR core.
//   jk_cmd_e    : JK command encodings, {J, K}
//   Q_RESET_VAL : value of Q after reset and at power-on
package sr_to_jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_e;

  localparam logic Q_RESET_VAL = 1'b0;

endpackage

// File: rtl/sr_ff.sv
// Clocked SR flip-flop with synchronous active-high reset.
//   clk : clock, rising edge
//   rst : synchronous reset, active high, forces q to Q_RESET_VAL
//   s   : set request
//   r   : reset request (s = r = 1 is illegal)
//   q   : stored state
//   q_n : complement of q, derived combinationally
module sr_ff
  import sr_to_jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_n
);

  // Initialiser gives a defined state before the first sampled reset.
  logic q_q = Q_RESET_VAL;
  logic q_d;

  // Explicit decode of Q+ = S | (~R & Q) so set and clear resolve even
  // when the present state is unknown. The illegal 11 follows the equation.
  always_comb begin
    q_d = q_q;
    case ({s, r})
      2'b10:   q_d = 1'b1;
      2'b01:   q_d = 1'b0;
      2'b11:   q_d = 1'b1;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= Q_RESET_VAL;
    else     q_q <= q_d;
  end

  assign q   = q_q;
  assign q_n = ~q_q;

endmodule

// File: rtl/sr_to_jk.sv
// JK flip-flop built around an SR flip-flop core.
//   q_    : flip-flop state Q
//   q_bar : complement of Q
//   clk   : clock, rising edge
//   rst   : synchronous reset, active high, priority over JK
//   JK    : {J, K} command: 00 hold, 01 clear, 10 set, 11 toggle
module sr_to_jk
  import sr_to_jk_pkg::*;
(
  output logic       q_,
  output logic       q_bar,
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] JK
);

  logic s;
  logic r;
  logic q_core;
  logic q_n_core;

  // Same truth table as S = J & ~Q, R = K & Q, but set and clear are
  // decoded straight from JK so they do not depend on Q being known.
  // Only toggle needs Q. S and R are never both 1.
  always_comb begin
    s = 1'b0;
    r = 1'b0;
    case (jk_cmd_e'(JK))
      JK_SET: s = 1'b1;
      JK_RST: r = 1'b1;
      JK_TOG: begin
        s = ~q_core;
        r = q_core;
      end
      default: begin
        s = 1'b0;
        r = 1'b0;
      end
    endcase
  end

  sr_ff u_sr_ff (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .r   (r),
    .q   (q_core),
    .q_n (q_n_core)
  );

  assign q_    = q_core;
  assign q_bar = q_n_core;

  always_ff @(posedge clk) begin
    assert (!(s && r));
    assert (q_bar == ~q_);
  end

endmodule

// File: tb/tb_sr_to_jk.sv
// Self-checking bench for sr_to_jk: directed test-plan sequences with
// literal expectations, then randomized JK/rst against a truth-table model.
module tb_sr_to_jk;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] JK  = 2'b00;
  logic       q_;
  logic       q_bar;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // JK flip-flop characteristic table: next_q[{J,K}][Q]
  bit next_q [4][2];
  bit exp_q = 1'b0;

  sr_to_jk dut (
    .q_    (q_),
    .q_bar (q_bar),
    .clk   (clk),
    .rst   (rst),
    .JK    (JK)
  );

  always #25 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: reset wins, otherwise look up the characteristic table.
  always @(posedge clk) begin
    if (rst) exp_q = 1'b0;
    else     exp_q = next_q[JK][exp_q];
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_q", q_, exp_q);
      chk("model_qbar", q_bar, ~exp_q);
    end
  end

  task automatic tick(input logic r_v, input logic [1:0] jk_v);
    @(negedge clk);
    rst = r_v;
    JK  = jk_v;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_exp(input string nm, input logic r_v, input logic [1:0] jk_v,
                          input logic q_exp);
    tick(r_v, jk_v);
    chk(nm, q_, q_exp);
    chk({nm, "_bar"}, q_bar, ~q_exp);
  endtask

  initial begin
    next_q[0][0] = 0; next_q[0][1] = 1;   // hold
    next_q[1][0] = 0; next_q[1][1] = 0;   // clear
    next_q[2][0] = 1; next_q[2][1] = 1;   // set
    next_q[3][0] = 1; next_q[3][1] = 0;   // toggle

    #1;
    chk("poweron_q", q_, 1'b0);
    chk("poweron_qbar", q_bar, 1'b1);
    cmp_en = 1'b1;

    // Reset then hold
    tick_exp("reset", 1'b1, 2'b00, 1'b0);
    tick_exp("hold0_a", 1'b0, 2'b00, 1'b0);
    tick_exp("hold0_b", 1'b0, 2'b00, 1'b0);

    // Set then hold
    tick_exp("set_a", 1'b0, 2'b10, 1'b1);
    tick_exp("set_b", 1'b0, 2'b10, 1'b1);
    tick_exp("hold1", 1'b0, 2'b00, 1'b1);

    // Clear command
    tick_exp("clr_a", 1'b0, 2'b01, 1'b0);
    tick_exp("clr_b", 1'b0, 2'b01, 1'b0);
    tick_exp("clr_c", 1'b0, 2'b01, 1'b0);

    // Toggle from 0 for four edges
    tick_exp("tog_1", 1'b0, 2'b11, 1'b1);
    tick_exp("tog_2", 1'b0, 2'b11, 1'b0);
    tick_exp("tog_3", 1'b0, 2'b11, 1'b1);
    tick_exp("tog_4", 1'b0, 2'b11, 1'b0);

    // Sequence: each command held for two edges
    tick_exp("seq_set_a", 1'b0, 2'b10, 1'b1);
    tick_exp("seq_set_b", 1'b0, 2'b10, 1'b1);
    tick_exp("seq_clr_a", 1'b0, 2'b01, 1'b0);
    tick_exp("seq_clr_b", 1'b0, 2'b01, 1'b0);
    tick_exp("seq_tog_a", 1'b0, 2'b11, 1'b1);
    tick_exp("seq_tog_b", 1'b0, 2'b11, 1'b0);
    tick_exp("seq_hold_a", 1'b0, 2'b00, 1'b0);
    tick_exp("seq_hold_b", 1'b0, 2'b00, 1'b0);
    tick_exp("seq_set2_a", 1'b0, 2'b10, 1'b1);
    tick_exp("seq_set2_b", 1'b0, 2'b10, 1'b1);

    // Reset priority during toggle
    tick_exp("rp_tog_1", 1'b0, 2'b11, 1'b0);
    tick_exp("rp_tog_2", 1'b0, 2'b11, 1'b1);
    tick_exp("rp_rst", 1'b1, 2'b11, 1'b0);
    tick_exp("rp_resume_1", 1'b0, 2'b11, 1'b1);
    tick_exp("rp_resume_2", 1'b0, 2'b11, 1'b0);

    // Reset priority over set
    tick_exp("rp_set", 1'b1, 2'b10, 1'b0);

    // Randomized traffic, checked by the model process
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
